// File: rtl/match_fsm.sv
// Match controller: menu/map selection, round and match sequencing, scoring.
// Optional MATCH_FSM_PAUSE_EN lets an Enter press pause a running round.
module match_fsm #(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned NUM_MAPS      = 2,
  parameter int unsigned ROUNDS_TO_WIN = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Reset_Game,
  input  logic                     Reset_Round,
  input  logic [NUM_PLAYERS-1:0]   Crash,
  input  logic [7:0]               keycode,
  output logic [2:0]               Game_State,
  output logic [2:0]               map_select,
  output logic                     load_background,
  output logic [NUM_PLAYERS-1:0]   alive,
  output logic [4*NUM_PLAYERS-1:0] score,
  output logic [1:0]               round_winner,
  output logic                     round_draw
);

  localparam int unsigned SW = 4 * NUM_PLAYERS;

  typedef enum logic [2:0] {
    MENU         = 3'd0,
    ROUND_PAUSED = 3'd1,
    ROUND_RUN    = 3'd2,
    ROUND_OVER   = 3'd3,
    MATCH_OVER   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             map_q, map_d;
  logic [SW-1:0]          score_q, score_d;
  logic [NUM_PLAYERS-1:0] alive_q, alive_d;
  logic [1:0]             winner_q, winner_d;
  logic                   draw_q, draw_d;
  logic                   load_q, load_d;
  logic [7:0]             prev_key_q;

  logic                   enter_c, up_c, down_c;
  logic [NUM_PLAYERS-1:0] alive_crash;
  logic [2:0]             alive_cnt;
  logic [1:0]             survivor;
  logic                   match_won;

  // A press is the first cycle a target key appears.
  assign enter_c = (keycode == 8'h28) && (keycode != prev_key_q);
  assign up_c    = ((keycode == 8'h1A) || (keycode == 8'h52)) && (keycode != prev_key_q);
  assign down_c  = ((keycode == 8'h16) || (keycode == 8'h51)) && (keycode != prev_key_q);

  assign alive_crash = alive_q & ~Crash;

  always_comb begin
    alive_cnt = 3'd0;
    survivor  = 2'd0;
    match_won = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (alive_crash[i]) begin
        alive_cnt = alive_cnt + 3'd1;
        survivor  = 2'(i);
      end
      if (score_q[4*i +: 4] == 4'(ROUNDS_TO_WIN)) match_won = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= MENU;
      map_q      <= 3'd0;
      score_q    <= '0;
      alive_q    <= '1;
      winner_q   <= 2'd0;
      draw_q     <= 1'b0;
      load_q     <= 1'b0;
      prev_key_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      map_q      <= map_d;
      score_q    <= score_d;
      alive_q    <= alive_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
      load_q     <= load_d;
      prev_key_q <= Reset_Game ? 8'h00 : keycode;
    end
  end

  always_comb begin
    state_d  = state_q;
    map_d    = map_q;
    score_d  = score_q;
    alive_d  = alive_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    load_d   = 1'b0;

    if (Reset_Game) begin
      state_d  = MENU;
      score_d  = '0;
      alive_d  = '1;
      winner_d = 2'd0;
      draw_d   = 1'b0;
    end else if (Reset_Round &&
                 ((state_q == ROUND_PAUSED) || (state_q == ROUND_RUN))) begin
      state_d = ROUND_PAUSED;
      alive_d = '1;
      load_d  = 1'b1;
    end else begin
      unique case (state_q)
        MENU: begin
          if (enter_c) begin
            state_d = ROUND_PAUSED;
            score_d = '0;
            alive_d = '1;
            draw_d  = 1'b0;
            load_d  = 1'b1;
          end else if (up_c) begin
            map_d = (map_q == 3'(NUM_MAPS - 1)) ? 3'd0 : map_q + 3'd1;
          end else if (down_c) begin
            map_d = (map_q == 3'd0) ? 3'(NUM_MAPS - 1) : map_q - 3'd1;
          end
        end
        ROUND_PAUSED: begin
          if (enter_c) state_d = ROUND_RUN;
        end
        ROUND_RUN: begin
          alive_d = alive_crash;
          if (alive_cnt <= 3'd1) begin
            state_d = ROUND_OVER;
            if (alive_cnt == 3'd1) begin
              winner_d = survivor;
              draw_d   = 1'b0;
              if (score_q[4*survivor +: 4] != 4'hF)
                score_d[4*survivor +: 4] = score_q[4*survivor +: 4] + 4'd1;
            end else begin
              draw_d = 1'b1;
            end
          end
`ifdef MATCH_FSM_PAUSE_EN
          else if (enter_c) begin
            state_d = ROUND_PAUSED;
          end
`endif
        end
        ROUND_OVER: begin
          if (enter_c) begin
            if (match_won) begin
              state_d = MATCH_OVER;
            end else begin
              state_d = ROUND_PAUSED;
              alive_d = '1;
              load_d  = 1'b1;
            end
          end
        end
        MATCH_OVER: begin
          if (enter_c) begin
            state_d = MENU;
            load_d  = 1'b1;
          end
        end
        default: state_d = MENU;
      endcase
    end
  end

  assign Game_State      = state_q;
  assign map_select      = map_q;
  assign load_background = load_q;
  assign alive           = alive_q;
  assign score           = score_q;
  assign round_winner    = winner_q;
  assign round_draw      = draw_q;

endmodule

// File: tb/tb_match_fsm.sv
// Directed bench for match_fsm: dut_a (3 maps, 3 wins) and dut_b (2 maps, 1 win) share stimulus.
module tb_match_fsm;

  localparam logic [7:0] K_ENTER = 8'h28;
  localparam logic [7:0] K_UP    = 8'h1A;
  localparam logic [7:0] K_DOWN  = 8'h51;

  logic       Clk, Reset, Reset_Game, Reset_Round;
  logic [1:0] Crash;
  logic [7:0] keycode;

  logic [2:0] gs_a, map_a, gs_b, map_b;
  logic       load_a, draw_a, load_b, draw_b;
  logic [1:0] alive_a, win_a, alive_b, win_b;
  logic [7:0] score_a, score_b;

  int n_vec = 0;
  int n_err = 0;

  match_fsm #(.NUM_PLAYERS(2), .NUM_MAPS(3), .ROUNDS_TO_WIN(3)) dut_a (
    .Clk(Clk), .Reset(Reset), .Reset_Game(Reset_Game), .Reset_Round(Reset_Round),
    .Crash(Crash), .keycode(keycode), .Game_State(gs_a), .map_select(map_a),
    .load_background(load_a), .alive(alive_a), .score(score_a),
    .round_winner(win_a), .round_draw(draw_a)
  );

  match_fsm #(.NUM_PLAYERS(2), .NUM_MAPS(2), .ROUNDS_TO_WIN(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .Reset_Game(Reset_Game), .Reset_Round(Reset_Round),
    .Crash(Crash), .keycode(keycode), .Game_State(gs_b), .map_select(map_b),
    .load_background(load_b), .alive(alive_b), .score(score_b),
    .round_winner(win_b), .round_draw(draw_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    tick();
    keycode = 8'h00;
    tick();
  endtask

  task automatic crash(input logic [1:0] c);
    Crash = c;
    tick();
    Crash = 2'b00;
  endtask

  initial begin
    Reset = 1'b1; Reset_Game = 1'b0; Reset_Round = 1'b0;
    Crash = 2'b00; keycode = 8'h00;
    #2 Reset = 1'b0;
    #1;
    check("rst_state", 32'(gs_a), 32'd0);
    check("rst_map", 32'(map_a), 32'd0);
    check("rst_score", 32'(score_a), 32'h00);
    check("rst_alive", 32'(alive_a), 32'h3);
    check("rst_load", 32'(load_a), 32'd0);
    check("rst_draw", 32'(draw_a), 32'd0);
    check("rst_winner", 32'(win_a), 32'd0);
    tick(); tick();
    Reset = 1'b1;
    tick();

    // Map selection with wrap on a 3-map build
    press(K_UP);   check("map_up1", 32'(map_a), 32'd1);
    press(K_UP);   check("map_up2", 32'(map_a), 32'd2);
    press(K_UP);   check("map_up3", 32'(map_a), 32'd0);
    press(K_DOWN); check("map_dn1", 32'(map_a), 32'd2);

    keycode = K_UP;
    for (int i = 0; i < 10; i++) tick();
    keycode = 8'h00;
    check("map_held", 32'(map_a), 32'd0);
    tick();

    keycode = K_ENTER; tick();
    check("start_state", 32'(gs_a), 32'd1);
    check("start_load", 32'(load_a), 32'd1);
    check("start_alive", 32'(alive_a), 32'h3);
    check("start_score", 32'(score_a), 32'h00);
    keycode = 8'h00; tick();
    check("start_load_end", 32'(load_a), 32'd0);
    press(K_ENTER); check("run_state", 32'(gs_a), 32'd2);

    crash(2'b01);
    check("r1_state", 32'(gs_a), 32'd3);
    check("r1_score", 32'(score_a), 32'h10);
    check("r1_winner", 32'(win_a), 32'd1);
    check("r1_draw", 32'(draw_a), 32'd0);
    check("r1_alive", 32'(alive_a), 32'h2);

    press(K_ENTER);
    check("next_state", 32'(gs_a), 32'd1);
    check("next_alive", 32'(alive_a), 32'h3);
    press(K_ENTER);

    crash(2'b11);
    check("draw_state", 32'(gs_a), 32'd3);
    check("draw_flag", 32'(draw_a), 32'd1);
    check("draw_score", 32'(score_a), 32'h10);

    press(K_ENTER); press(K_ENTER);
    crash(2'b10);
    check("r3_score", 32'(score_a), 32'h11);
    check("r3_winner", 32'(win_a), 32'd0);
    check("r3_draw", 32'(draw_a), 32'd0);
    press(K_ENTER); press(K_ENTER);
    crash(2'b10);
    check("r4_score", 32'(score_a), 32'h12);
    press(K_ENTER); press(K_ENTER);
    check("r5_run", 32'(gs_a), 32'd2);

    keycode = K_ENTER; tick();
    keycode = 8'h00; tick();
`ifdef MATCH_FSM_PAUSE_EN
    check("pause_state", 32'(gs_a), 32'd1);
    check("pause_alive", 32'(alive_a), 32'h3);
    check("pause_load", 32'(load_a), 32'd0);
    press(K_ENTER);
`else
    check("no_pause_state", 32'(gs_a), 32'd2);
`endif

    // Reset_Round outranks a simultaneous crash
    Reset_Round = 1'b1; Crash = 2'b01; tick();
    Reset_Round = 1'b0; Crash = 2'b00;
    check("rr_state", 32'(gs_a), 32'd1);
    check("rr_alive", 32'(alive_a), 32'h3);
    check("rr_score", 32'(score_a), 32'h12);
    check("rr_load", 32'(load_a), 32'd1);
    crash(2'b01);
    check("paused_crash_alive", 32'(alive_a), 32'h3);
    check("paused_crash_state", 32'(gs_a), 32'd1);
    press(K_ENTER);
    check("rr_run", 32'(gs_a), 32'd2);

    Reset = 1'b0;
    #2;
    check("async_state", 32'(gs_a), 32'd0);
    check("async_score", 32'(score_a), 32'h00);
    check("async_alive", 32'(alive_a), 32'h3);
    check("async_map", 32'(map_a), 32'd0);
    tick();
    Reset = 1'b1;
    tick();

    press(K_DOWN);
    check("wrap_dn_a", 32'(map_a), 32'd2);
    check("wrap_dn_b", 32'(map_b), 32'd1);
    press(K_UP);
    check("wrap_up_b", 32'(map_b), 32'd0);

    // One-round match on dut_b
    press(K_ENTER); press(K_ENTER);
    check("b_run", 32'(gs_b), 32'd2);
    crash(2'b10);
    check("b_over", 32'(gs_b), 32'd3);
    check("b_score", 32'(score_b), 32'h01);
    check("b_winner", 32'(win_b), 32'd0);
    press(K_ENTER);
    check("b_match", 32'(gs_b), 32'd4);
    keycode = K_ENTER; tick();
    check("b_menu", 32'(gs_b), 32'd0);
    check("b_menu_load", 32'(load_b), 32'd1);
    keycode = 8'h00; tick();
    check("b_menu_load_end", 32'(load_b), 32'd0);
    check("b_score_held", 32'(score_b), 32'h01);

    press(K_UP);
    check("b_map", 32'(map_b), 32'd1);
    press(K_ENTER);
    check("b_paused", 32'(gs_b), 32'd1);
    check("b_clear", 32'(score_b), 32'h00);
    Reset_Game = 1'b1; tick(); Reset_Game = 1'b0;
    check("rg_state", 32'(gs_b), 32'd0);
    check("rg_map", 32'(map_b), 32'd1);
    check("rg_alive", 32'(alive_b), 32'h3);
    check("rg_load", 32'(load_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
